// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC-8 (x^8+x^5+x^3+x^2+1) frame controller.
package crc8_pkg;

   localparam logic [7:0] CRC8_POLY = 8'h2D;
   localparam logic [7:0] CRC8_INIT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      APPEND
   } state_t;

endpackage

// File: rtl/crc8_frame_ctrl_if.sv
// Byte stream with valid/ready handshake and end-of-frame marker.
interface crc8_frame_ctrl_if;

   logic       valid;
   logic       ready;
   logic [7:0] data;
   logic       last;

   modport master (output valid, data, last, input ready);
   modport slave  (input valid, data, last, output ready);

endinterface

// File: rtl/crc8_byte_step.sv
// One-byte parallel CRC-8 update, polynomial 0x2D, purely combinational.
module crc8_byte_step (
   input  logic [7:0] crc_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   logic [7:0] x;

   assign x = crc_i ^ data_i;

   assign crc_o[0] = x[0] ^ x[3] ^ x[5];
   assign crc_o[1] = x[1] ^ x[4] ^ x[6];
   assign crc_o[2] = x[0] ^ x[2] ^ x[3] ^ x[7];
   assign crc_o[3] = x[0] ^ x[1] ^ x[4] ^ x[5];
   assign crc_o[4] = x[1] ^ x[2] ^ x[5] ^ x[6];
   assign crc_o[5] = x[0] ^ x[2] ^ x[5] ^ x[6] ^ x[7];
   assign crc_o[6] = x[1] ^ x[3] ^ x[6] ^ x[7];
   assign crc_o[7] = x[2] ^ x[4] ^ x[7];

endmodule

// File: rtl/crc8_frame_ctrl.sv
// CRC-8 frame generator/checker with one output register stage.
// Optional error counter output err_cnt when CRC8_FRAME_ERR_CNT_EN is defined.
module crc8_frame_ctrl
   import crc8_pkg::*;
#(
   parameter int         MAX_LEN = 256,
   parameter logic [7:0] INIT    = CRC8_INIT
) (
   input  logic clk,
   input  logic rst,
   input  logic mode_i,
   crc8_frame_ctrl_if.slave  s,
   crc8_frame_ctrl_if.master m,
   output logic chk_valid,
   output logic chk_pass,
   output logic len_err,
   output logic busy
`ifdef CRC8_FRAME_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   state_t      state, state_d;
   logic [7:0]  crc, crc_base, crc_next;
   logic [15:0] len, len_next;
   logic [31:0] len_w, lim_w;
   logic        mode, mode_eff;
   logic        accept, frame_end, drain_ok, crc_done, too_long;

   assign drain_ok  = !m.valid || m.ready;
   assign s.ready   = (state != APPEND) && drain_ok;
   assign accept    = s.valid && s.ready;
   assign frame_end = accept && s.last;
   assign crc_done  = (state == APPEND) && m.valid && m.ready && m.last;
   assign busy      = (state != IDLE);

   // Mode is taken live from mode_i only for the first byte of a frame.
   assign mode_eff = (state == IDLE) ? mode_i : mode;
   assign crc_base = (state == IDLE) ? INIT : crc;
   assign len_next = (state == IDLE) ? 16'd1 :
                     (&len ? len : len + 16'd1);

   // Check frames carry one extra trailing CRC byte beyond the data.
   assign len_w    = {16'd0, len_next};
   assign lim_w    = 32'(MAX_LEN) + {31'd0, mode_eff};
   assign too_long = len_w > lim_w;

   crc8_byte_step u_step (
      .crc_i (crc_base),
      .data_i(s.data),
      .crc_o (crc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE, DATA: begin
            if (frame_end)   state_d = mode_eff ? IDLE : APPEND;
            else if (accept) state_d = DATA;
         end
         APPEND: if (crc_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc       <= INIT;
         len       <= 16'd0;
         mode      <= 1'b0;
         m.valid   <= 1'b0;
         m.data    <= 8'd0;
         m.last    <= 1'b0;
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         len_err   <= 1'b0;
      end else begin
         chk_valid <= 1'b0;
         chk_pass  <= 1'b0;
         len_err   <= 1'b0;
         if (accept) begin
            m.valid <= 1'b1;
            m.data  <= s.data;
            m.last  <= mode_eff && s.last;
            if (state == IDLE) mode <= mode_i;
            if (s.last) begin
               len       <= 16'd0;
               len_err   <= too_long;
               crc       <= mode_eff ? INIT : crc_next;
               chk_valid <= mode_eff;
               chk_pass  <= mode_eff && (crc_next == 8'd0) && !too_long;
            end else begin
               len <= len_next;
               crc <= crc_next;
            end
         end else if ((state == APPEND) && drain_ok) begin
            // m.last marks the CRC byte itself; anything else is the last data byte.
            if (m.valid && m.last) begin
               m.valid <= 1'b0;
               crc     <= INIT;
            end else begin
               m.valid <= 1'b1;
               m.data  <= crc;
               m.last  <= 1'b1;
            end
         end else if (m.ready) begin
            m.valid <= 1'b0;
         end
      end
   end

`ifdef CRC8_FRAME_ERR_CNT_EN
   logic [16:0] err_sum;

   assign err_sum = {1'b0, err_cnt}
                  + {16'd0, chk_valid && !chk_pass}
                  + {16'd0, len_err};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_cnt <= 16'd0;
      else     err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Self-checking bench for crc8_frame_ctrl (MAX_LEN = 2).
module tb_crc8_frame_ctrl;

   localparam int ML = 2;

   logic clk = 1'b0;
   logic rst;
   logic mode_i;
   logic chk_valid, chk_pass, len_err, busy;
`ifdef CRC8_FRAME_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   crc8_frame_ctrl_if s_if ();
   crc8_frame_ctrl_if m_if ();

   always #5 clk = ~clk;

   crc8_frame_ctrl #(.MAX_LEN(ML), .INIT(8'hFF)) dut (
      .clk      (clk),
      .rst      (rst),
      .mode_i   (mode_i),
      .s        (s_if),
      .m        (m_if),
      .chk_valid(chk_valid),
      .chk_pass (chk_pass),
      .len_err  (len_err),
      .busy     (busy)
`ifdef CRC8_FRAME_ERR_CNT_EN
      ,
      .err_cnt  (err_cnt)
`endif
   );

   int n_run  = 0;
   int n_fail = 0;
   int exp_err = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference CRC: each output bit is the parity of x under a fixed mask.
   function automatic logic [7:0] ref_step(logic [7:0] c, logic [7:0] b);
      logic [63:0] mk;
      logic [7:0]  x, r;
      mk = 64'h94CA_E566_338D_5229;
      x  = c ^ b;
      for (int i = 0; i < 8; i++) r[i] = ^(x & mk[i*8 +: 8]);
      return r;
   endfunction

   function automatic logic [7:0] ref_crc(input logic [7:0] d[$]);
      logic [7:0] c;
      c = 8'hFF;
      foreach (d[i]) c = ref_step(c, d[i]);
      return c;
   endfunction

   // Monitor state
   bit         rnd_ready = 1'b0;
   bit         cur_md = 1'b0;
   bit         app = 1'b0;
   bit         pstall = 1'b0;
   logic       plast;
   logic [7:0] pdata;
   logic [8:0] obs_q[$];
   bit         chk_q[$];
   int         lerr_n = 0;

   always @(negedge clk) begin
      if (rst) begin
         app    = 1'b0;
         pstall = 1'b0;
      end else begin
         if (pstall)
            check("m_hold", {m_if.valid, m_if.last, m_if.data},
                  {1'b1, plast, pdata});
         pstall = m_if.valid && !m_if.ready;
         plast  = m_if.last;
         pdata  = m_if.data;
         if (app) check("s_ready_in_append", s_if.ready, 0);
         if (m_if.valid && m_if.ready) begin
            obs_q.push_back({m_if.last, m_if.data});
            if (m_if.last) app = 1'b0;
         end
         if (s_if.valid && s_if.ready && s_if.last && !cur_md) app = 1'b1;
         if (chk_valid) chk_q.push_back(chk_pass);
         if (len_err) lerr_n++;
      end
   end

   initial begin
      m_if.ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_if.ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic send(input bit md, input logic [7:0] d[$],
                       input bit fin, input bit gaps);
      cur_md = md;
      foreach (d[i]) begin
         int  t;
         bit  acc;
         if (gaps) repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         s_if.valid = 1'b1;
         s_if.data  = d[i];
         s_if.last  = fin && (i == d.size() - 1);
         mode_i     = (i == 0) ? md : 1'($urandom);
         t = 0;
         do begin
            @(negedge clk);
            acc = s_if.ready;
            @(posedge clk);
            #1;
            t++;
         end while (!acc && t < 100);
         if (!acc) check("s_accept_timeout", 0, 1);
         s_if.valid = 1'b0;
         s_if.last  = 1'b0;
      end
   endtask

   task automatic expect_frame(input string nm, input bit md,
                               input logic [7:0] d[$], input logic [7:0] ecrc,
                               input bit epass, input bit elen);
      logic [8:0] exp[$];
      int t;
      foreach (d[i]) exp.push_back({md && (i == d.size() - 1), d[i]});
      if (!md) exp.push_back({1'b1, ecrc});
      t = 0;
      while ((obs_q.size() < exp.size() || (md && chk_q.size() == 0))
             && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check({nm, "_nbytes"}, obs_q.size(), exp.size());
      foreach (exp[i])
         if (i < obs_q.size()) check({nm, "_byte"}, obs_q[i], exp[i]);
      check({nm, "_nchk"}, chk_q.size(), {31'd0, md});
      if (md && chk_q.size() > 0) check({nm, "_pass"}, chk_q[0], epass);
      check({nm, "_len_err"}, lerr_n, {31'd0, elen});
      check({nm, "_busy"}, busy, 0);
      exp_err += ((md && !epass) ? 1 : 0) + (elen ? 1 : 0);
      if (exp_err > 65535) exp_err = 65535;
`ifdef CRC8_FRAME_ERR_CNT_EN
      check({nm, "_err_cnt"}, err_cnt, exp_err);
`endif
      obs_q.delete();
      chk_q.delete();
      lerr_n = 0;
   endtask

   task automatic run_model(input string nm, input bit md,
                            input logic [7:0] d[$], input bit gaps);
      logic [7:0] c;
      int n;
      c = ref_crc(d);
      n = d.size();
      send(md, d, 1'b1, gaps);
      expect_frame(nm, md, d, c, (c == 8'd0) && (n <= ML + 1),
                   md ? (n > ML + 1) : (n > ML));
   endtask

   typedef struct {
      bit         md;
      int         n;
      logic [7:0] d[4];
      logic [7:0] ecrc;
      bit         epass;
      bit         elen;
   } vec_t;

   vec_t tbl[10];

   task automatic set_vec(input int k, input bit md, input int n,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3,
                          input logic [7:0] ecrc, input bit epass,
                          input bit elen);
      tbl[k].md    = md;
      tbl[k].n     = n;
      tbl[k].d[0]  = d0;
      tbl[k].d[1]  = d1;
      tbl[k].d[2]  = d2;
      tbl[k].d[3]  = d3;
      tbl[k].ecrc  = ecrc;
      tbl[k].epass = epass;
      tbl[k].elen  = elen;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];

      set_vec(0, 0, 1, 8'h00, 0, 0, 0, 8'hA3, 0, 0);
      set_vec(1, 0, 1, 8'hFF, 0, 0, 0, 8'h00, 0, 0);
      set_vec(2, 1, 2, 8'h00, 8'hA3, 0, 0, 0, 1, 0);
      set_vec(3, 1, 2, 8'h00, 8'hA2, 0, 0, 0, 0, 0);
      set_vec(4, 0, 2, 8'hFF, 8'hFF, 0, 0, 8'hA3, 0, 0);
      set_vec(5, 0, 3, 8'hFF, 8'hFF, 8'hFF, 0, 8'h09, 0, 1);
      set_vec(6, 1, 3, 8'hFF, 8'hFF, 8'hA3, 0, 0, 1, 0);
      set_vec(7, 1, 4, 8'hFF, 8'hFF, 8'hFF, 8'h09, 0, 0, 1);
      set_vec(8, 1, 1, 8'hFF, 0, 0, 0, 0, 1, 0);
      set_vec(9, 1, 1, 8'h00, 0, 0, 0, 0, 0, 0);

      rst        = 1'b1;
      mode_i     = 1'b0;
      s_if.valid = 1'b0;
      s_if.data  = 8'd0;
      s_if.last  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_m_valid", m_if.valid, 0);
      check("rst_m_data", m_if.data, 0);
      check("rst_m_last", m_if.last, 0);
      check("rst_busy", busy, 0);
      check("rst_chk", {chk_valid, chk_pass, len_err}, 0);
      check("rst_s_ready", s_if.ready, 1);
`ifdef CRC8_FRAME_ERR_CNT_EN
      check("rst_err_cnt", err_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (tbl[k]) begin
         q.delete();
         for (int i = 0; i < tbl[k].n; i++) q.push_back(tbl[k].d[i]);
         send(tbl[k].md, q, 1'b1, 1'b0);
         expect_frame($sformatf("vec%0d", k), tbl[k].md, q, tbl[k].ecrc,
                      tbl[k].epass, tbl[k].elen);
      end

      // Reset in the middle of a generate frame, then a clean frame.
      q.delete();
      q.push_back(8'h11);
      q.push_back(8'h22);
      send(1'b0, q, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_m_valid", m_if.valid, 0);
      check("midrst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      chk_q.delete();
      lerr_n  = 0;
      exp_err = 0;
      q.delete();
      q.push_back(8'h00);
      send(1'b0, q, 1'b1, 1'b0);
      expect_frame("after_rst", 1'b0, q, 8'hA3, 1'b0, 1'b0);

      // Stalled 4-byte generate frame.
      rnd_ready = 1'b1;
      q.delete();
      for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
      run_model("gen4_stall", 1'b0, q, 1'b0);

      // Randomized frames in both modes.
      for (int f = 0; f < 60; f++) begin
         bit md;
         int n;
         md = 1'($urandom);
         n  = $urandom_range(1, 5);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(8'($urandom));
         if (md && n > 1 && $urandom_range(0, 1) == 1) begin
            void'(q.pop_back());
            q.push_back(ref_crc(q));
         end
         run_model($sformatf("rnd%0d", f), md, q, 1'($urandom));
      end
      rnd_ready = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
